// File: rtl/handshake_pkg.sv
// Shared constants and helpers for the handshake skid FIFO.
package handshake_pkg;

    localparam int HSK_MIN_DEPTH = 2;

    // Width needed to hold an occupancy in 0..depth inclusive.
    function automatic int hsk_lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/handshake_skid_fifo_if.sv
// Valid/ready stream bundle: upstream (d_*) into the FIFO, downstream (s_*) out of it.
interface handshake_skid_fifo_if #(
    parameter int DATA_W = 8
);
    import handshake_pkg::*;

    // A word moves on a rising clk edge exactly when valid and ready are both 1;
    // once raised, valid holds with stable data until that transfer happens.
    logic              d_valid_i;
    logic [DATA_W-1:0] d_data_i;
    logic              d_ready_o;
    logic              s_valid_o;
    logic [DATA_W-1:0] s_data_o;
    logic              s_ready_i;

    modport slave (
        input  d_valid_i,
        input  d_data_i,
        output d_ready_o,
        output s_valid_o,
        output s_data_o,
        input  s_ready_i
    );

    modport master (
        output d_valid_i,
        output d_data_i,
        input  d_ready_o,
        input  s_valid_o,
        input  s_data_o,
        output s_ready_i
    );

endinterface

// File: rtl/handshake_fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one asynchronous read port.
module handshake_fifo_mem
    import handshake_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage is deliberately not reset; valid data is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/handshake_skid_fifo.sv
// Fully registered valid/ready FIFO of DEPTH entries; level_o exists only when HSK_LEVEL_EN is defined.
module handshake_skid_fifo
    import handshake_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    handshake_skid_fifo_if.slave           bus
`ifdef HSK_LEVEL_EN
    ,
    output logic [hsk_lvl_w(DEPTH)-1:0]    level_o
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = hsk_lvl_w(DEPTH);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    if (DEPTH < HSK_MIN_DEPTH || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("handshake_skid_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic [LVL_W-1:0]  count;
    logic [LVL_W-1:0]  count_next;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] next_head;

    assign push = bus.d_valid_i && bus.d_ready_o;
    assign pop  = bus.s_valid_o && bus.s_ready_i;

    // The memory holds every queued word; s_data_o is a registered copy of the head.
    handshake_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wptr),
        .wdata (bus.d_data_i),
        .raddr (rptr + PTR_ONE),
        .rdata (next_head)
    );

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + LVL_ONE;
        end else if (pop && !push) begin
            count_next = count - LVL_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr          <= '0;
            rptr          <= '0;
            count         <= '0;
            bus.d_ready_o <= 1'b0;
            bus.s_valid_o <= 1'b0;
            bus.s_data_o  <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_ONE;
            end
            if (pop) begin
                rptr <= rptr + PTR_ONE;
            end
            count         <= count_next;
            bus.d_ready_o <= (count_next < LVL_FULL);
            bus.s_valid_o <= (count_next != '0);
            // With two or more queued, the entry behind the head is already in memory.
            if (pop && count > LVL_ONE) begin
                bus.s_data_o <= next_head;
            end else if (push && (count == '0 || (pop && count == LVL_ONE))) begin
                bus.s_data_o <= bus.d_data_i;
            end
        end
    end

`ifdef HSK_LEVEL_EN
    assign level_o = count;
`endif

endmodule
